multicycle_controller: RTL and testbench

//  Parametrised multicycle successor to the single-cycle ARM control decoder.

---
 rtl/multicycle_controller_pkg.sv | 54 +++++
 rtl/multicycle_controller_if.sv | 42 ++++
 rtl/multicycle_controller_alu_decoder.sv | 36 +++
 rtl/multicycle_controller.sv | 156 +++++++++++++++
 tb/tb_multicycle_controller.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle ARM controller: FSM encodings, ALU and
// shifter opcodes, flag-write bit positions and datapath mux selections.
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_SHREG  = 4'd2;
  localparam logic [3:0] S_EXECR  = 4'd3;
  localparam logic [3:0] S_EXECI  = 4'd4;
  localparam logic [3:0] S_ALUWB  = 4'd5;
  localparam logic [3:0] S_MEMADR = 4'd6;
  localparam logic [3:0] S_MEMRD  = 4'd7;
  localparam logic [3:0] S_MEMWB  = 4'd8;
  localparam logic [3:0] S_MEMWR  = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_EOR = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_RSB = 4'h3;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_ADC = 4'h5;
  localparam logic [3:0] ALU_SBC = 4'h6;
  localparam logic [3:0] ALU_RSC = 4'h7;
  localparam logic [3:0] ALU_TST = 4'h8;
  localparam logic [3:0] ALU_TEQ = 4'h9;
  localparam logic [3:0] ALU_CMP = 4'hA;
  localparam logic [3:0] ALU_CMN = 4'hB;
  localparam logic [3:0] ALU_ORR = 4'hC;
  localparam logic [3:0] ALU_MOV = 4'hD;
  localparam logic [3:0] ALU_BIC = 4'hE;
  localparam logic [3:0] ALU_MVN = 4'hF;

  localparam logic [2:0] SH_LSL = 3'd0;
  localparam logic [2:0] SH_LSR = 3'd1;
  localparam logic [2:0] SH_ASR = 3'd2;
  localparam logic [2:0] SH_ROR = 3'd3;
  localparam logic [2:0] SH_RRX = 3'd4;

  localparam int NEG = 3;
  localparam int ZER = 2;
  localparam int CAR = 1;
  localparam int OVR = 0;

  typedef enum logic [1:0] {RES_ALUOUT = 2'd0, RES_DATA = 2'd1, RES_ALU = 2'd2} result_src_e;
  typedef enum logic [1:0] {SRCA_RN = 2'd0, SRCA_PC = 2'd1, SRCA_ALUOUT = 2'd2} src_a_e;
  typedef enum logic [1:0] {SRCB_RM = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2} src_b_e;

  // TST/TEQ/CMP/CMN occupy opcodes 8..B and never write a destination register
  function automatic logic is_test_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> instruction-register/datapath bundle: IR fields and memory
// handshake in, datapath control strobes and selects out.
interface multicycle_controller_if #(
  parameter int ALU_CTRL_W = 4,
  parameter int SHIFT_OP_W = 3
);
  logic [1:0]            Op;
  logic [5:0]            Funct;
  logic [3:0]            Rd;
  logic [7:0]            Instr;
  logic                  MemReady;
  logic                  IRWrite;
  logic                  PCWrite;
  logic                  RegW;
  logic                  MemW;
  logic                  AdrSrc;
  logic [1:0]            ResultSrc;
  logic [1:0]            ALUSrcA;
  logic [1:0]            ALUSrcB;
  logic [1:0]            ImmSrc;
  logic [1:0]            RegSrc;
  logic [ALU_CTRL_W-1:0] ALUControl;
  logic [3:0]            FlagW;
  logic [SHIFT_OP_W-1:0] shiftOp;
  logic                  registerShift;
  logic                  linkSelect;
  logic                  NoWrite;

  modport master (
    input  Op, Funct, Rd, Instr, MemReady,
    output IRWrite, PCWrite, RegW, MemW, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, ALUControl, FlagW, shiftOp, registerShift,
           linkSelect, NoWrite
  );

  modport slave (
    output Op, Funct, Rd, Instr, MemReady,
    input  IRWrite, PCWrite, RegW, MemW, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, ALUControl, FlagW, shiftOp, registerShift,
           linkSelect, NoWrite
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Data-processing ALU decoder: maps the opcode/S bits to ALU opcode, flag
// write enables and the compare-class NoWrite marker.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [4:0]            Funct,
  input  logic                  is_dp,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic [3:0]            FlagW,
  output logic                  NoWrite
);

  logic [3:0] op;
  assign op = Funct[4:1];

  always_comb begin
    NoWrite    = is_test_op(op);
    ALUControl = ALU_CTRL_W'(ALU_ADD);
    FlagW      = 4'b0000;
    if (is_dp) begin
      ALUControl = ALU_CTRL_W'(op);
      FlagW[NEG] = Funct[0];
      FlagW[ZER] = Funct[0];
      FlagW[CAR] = Funct[0];
      // compares always update flags; CMP/CMN also own the overflow flag
      case (op)
        ALU_CMP, ALU_CMN: FlagW = 4'b1111;
        ALU_TST, ALU_TEQ: FlagW[3:1] = 3'b111;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback with a variable-latency memory handshake.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W  = 4,
  parameter int SHIFT_OP_W  = 3,
  parameter int EN_BL       = 1,
  parameter int EN_REGSHIFT = 1
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);

  localparam logic BL_ON       = (EN_BL != 0);
  localparam logic REGSHIFT_ON = (EN_REGSHIFT != 0);

  logic [3:0]  state;
  logic [3:0]  next_state;
  logic        is_dp;
  logic        reg_shift;
  logic        no_write;
  logic        irwrite;
  logic        pcwrite;
  logic        regw;
  logic        memw;
  logic        adr_src;
  logic        link;
  logic [2:0]  shift_op;
  result_src_e result_src;
  src_a_e      src_a;
  src_b_e      src_b;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  assign reg_shift = ~bus.Funct[5] & bus.Instr[0] & ~bus.Instr[3];

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Op)
          2'b00: begin
            if (bus.Funct[5])                   next_state = S_EXECI;
            else if (reg_shift && REGSHIFT_ON)  next_state = S_SHREG;
            else                                next_state = S_EXECR;
          end
          2'b01:   next_state = S_MEMADR;
          default: next_state = S_BRANCH;
        endcase
      end
      S_SHREG:  next_state = S_EXECR;
      S_EXECR:  next_state = S_ALUWB;
      S_EXECI:  next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_MEMADR: next_state = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = bus.MemReady ? S_FETCH : S_MEMWR;
      S_BRANCH: next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // Per-state datapath controls; unlisted states keep the idle defaults
  always_comb begin
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    adr_src    = 1'b0;
    link       = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_RN;
    src_b      = SRCB_RM;
    case (state)
      S_FETCH: begin
        irwrite    = bus.MemReady;
        pcwrite    = bus.MemReady;
        result_src = RES_ALU;
        src_a      = SRCA_PC;
        src_b      = SRCB_FOUR;
      end
      S_DECODE: begin
        src_a = SRCA_PC;
        src_b = SRCB_FOUR;
      end
      S_EXECI:  src_b = SRCB_IMM;
      S_ALUWB: begin
        regw    = ~no_write;
        pcwrite = (bus.Rd == 4'd15) & ~no_write;
      end
      S_MEMADR: src_b = SRCB_IMM;
      S_MEMRD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        regw       = 1'b1;
        pcwrite    = (bus.Rd == 4'd15);
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        memw    = 1'b1;
      end
      S_BRANCH: begin
        src_a      = SRCA_ALUOUT;
        src_b      = SRCB_IMM;
        result_src = RES_ALU;
        pcwrite    = 1'b1;
        regw       = (bus.Op == 2'b11) & BL_ON;
        link       = (bus.Op == 2'b11) & BL_ON;
      end
      default: ;
    endcase
  end

  // Immediates take the rotate path; RRX is the ROR #0 encoding
  always_comb begin
    if (bus.Funct[5])
      shift_op = SH_ROR;
    else if (bus.Instr[7:3] == 5'd0 && bus.Instr[2:1] == 2'b11 && !bus.Instr[0])
      shift_op = SH_RRX;
    else
      shift_op = {1'b0, bus.Instr[2:1]};
  end

  assign is_dp = (state == S_EXECR) || (state == S_EXECI);

  mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .Funct      (bus.Funct[4:0]),
    .is_dp      (is_dp),
    .ALUControl (bus.ALUControl),
    .FlagW      (bus.FlagW),
    .NoWrite    (no_write)
  );

  assign bus.IRWrite       = irwrite & ~reset;
  assign bus.PCWrite       = pcwrite & ~reset;
  assign bus.RegW          = regw & ~reset;
  assign bus.MemW          = memw & ~reset;
  assign bus.AdrSrc        = adr_src;
  assign bus.ResultSrc     = result_src;
  assign bus.ALUSrcA       = src_a;
  assign bus.ALUSrcB       = src_b;
  assign bus.ImmSrc        = bus.Op;
  assign bus.RegSrc        = {(bus.Op == 2'b01) & ~bus.Funct[0], bus.Op[1]};
  assign bus.shiftOp       = SHIFT_OP_W'(shift_op);
  assign bus.registerShift = reg_shift;
  assign bus.linkSelect    = link;
  assign bus.NoWrite       = no_write;

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle scoreboard bench for multicycle_controller: one instance with
// BL enabled and one with BL disabled share the same instruction stream.
module tb_multicycle_controller;

  typedef struct packed {
    logic       irw, pcw, regw, memw, adr;
    logic [1:0] res, srca, srcb;
    logic [3:0] alu, flagw;
    logic       link;
  } core_t;

  typedef struct packed {
    logic [1:0] imm, regsrc;
    logic [2:0] shop;
    logic       rsh, nowr;
  } irx_t;

  typedef struct packed {
    core_t c;
    irx_t  x;
    logic  bl;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [7:0] instr;
  logic       memReady;
  irx_t       curIrx;
  sb_t        sbQueue[$];
  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  multicycle_controller_if busBl ();
  multicycle_controller_if busNoBl ();

  assign busBl.Op         = op;
  assign busBl.Funct      = funct;
  assign busBl.Rd         = rd;
  assign busBl.Instr      = instr;
  assign busBl.MemReady   = memReady;
  assign busNoBl.Op       = op;
  assign busNoBl.Funct    = funct;
  assign busNoBl.Rd       = rd;
  assign busNoBl.Instr    = instr;
  assign busNoBl.MemReady = memReady;

  multicycle_controller #(.EN_BL(1)) dutBl (
    .clk   (clk),
    .reset (reset),
    .bus   (busBl)
  );

  multicycle_controller #(.EN_BL(0)) dutNoBl (
    .clk   (clk),
    .reset (reset),
    .bus   (busNoBl)
  );

  function automatic core_t mk(input logic irw, pcw, regw, memw, adr,
                               input logic [1:0] res, srca, srcb,
                               input logic [3:0] alu, flagw, input logic link);
    return '{irw, pcw, regw, memw, adr, res, srca, srcb, alu, flagw, link};
  endfunction

  function automatic core_t fetchExp(input logic mr);
    return mk(mr, mr, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'h4, 4'h0, 0);
  endfunction

  function automatic core_t decodeExp();
    return mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 4'h4, 4'h0, 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    if (obs !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic setInstr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                          input logic [7:0] i, input irx_t x);
    op = o; funct = f; rd = r; instr = i; curIrx = x;
  endtask

  // Drive one cycle, queue its expectation, then score it away from the edge
  task automatic applyStimulus(input logic mr, input logic rst, input core_t c, input logic bl);
    sb_t e;
    memReady = mr;
    reset    = rst;
    sbQueue.push_back('{c, curIrx, bl});
    @(negedge clk);
    e = sbQueue.pop_front();
    checkOutput("IRWrite",    32'(busBl.IRWrite),       32'(e.c.irw));
    checkOutput("PCWrite",    32'(busBl.PCWrite),       32'(e.c.pcw));
    checkOutput("RegW",       32'(busBl.RegW),          32'(e.c.regw));
    checkOutput("MemW",       32'(busBl.MemW),          32'(e.c.memw));
    checkOutput("AdrSrc",     32'(busBl.AdrSrc),        32'(e.c.adr));
    checkOutput("ResultSrc",  32'(busBl.ResultSrc),     32'(e.c.res));
    checkOutput("ALUSrcA",    32'(busBl.ALUSrcA),       32'(e.c.srca));
    checkOutput("ALUSrcB",    32'(busBl.ALUSrcB),       32'(e.c.srcb));
    checkOutput("ALUControl", 32'(busBl.ALUControl),    32'(e.c.alu));
    checkOutput("FlagW",      32'(busBl.FlagW),         32'(e.c.flagw));
    checkOutput("linkSelect", 32'(busBl.linkSelect),    32'(e.c.link));
    checkOutput("ImmSrc",     32'(busBl.ImmSrc),        32'(e.x.imm));
    checkOutput("RegSrc",     32'(busBl.RegSrc),        32'(e.x.regsrc));
    checkOutput("shiftOp",    32'(busBl.shiftOp),       32'(e.x.shop));
    checkOutput("regShift",   32'(busBl.registerShift), 32'(e.x.rsh));
    checkOutput("NoWrite",    32'(busBl.NoWrite),       32'(e.x.nowr));
    checkOutput("noBl.PCWrite",    32'(busNoBl.PCWrite),    32'(e.c.pcw));
    checkOutput("noBl.RegW",       32'(busNoBl.RegW),       32'(e.bl ? 1'b0 : e.c.regw));
    checkOutput("noBl.linkSelect", 32'(busNoBl.linkSelect), 32'(e.bl ? 1'b0 : e.c.link));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    core_t idle, memAdr, memRd, memWr;
    idle   = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'h4, 4'h0, 0);
    memAdr = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 4'h4, 4'h0, 0);
    memRd  = mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 4'h4, 4'h0, 0);
    memWr  = mk(0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 4'h4, 4'h0, 0);

    reset = 1'b1;
    memReady = 1'b1;
    setInstr(2'b00, 6'b101000, 4'd1, 8'h00, '{2'b00, 2'b00, 3'd3, 1'b0, 1'b0});
    @(posedge clk);
    #1;

    // reset held: FETCH selects but strobes forced low despite MemReady
    applyStimulus(1, 1, mk(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'h4, 4'h0, 0), 0);
    applyStimulus(1, 1, mk(0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 4'h4, 4'h0, 0), 0);

    // ADD r1,r2,#5
    applyStimulus(1, 0, fetchExp(1), 0);
    applyStimulus(1, 0, decodeExp(), 0);
    applyStimulus(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 4'h4, 4'h0, 0), 0);
    applyStimulus(1, 0, mk(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'h4, 4'h0, 0), 0);

    // LDR r2 with three wait cycles in MEMRD
    setInstr(2'b01, 6'b011001, 4'd2, 8'h00, '{2'b01, 2'b00, 3'd0, 1'b0, 1'b0});
    applyStimulus(1, 0, fetchExp(1), 0);
    applyStimulus(1, 0, decodeExp(), 0);
    applyStimulus(1, 0, memAdr, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, memRd, 0);
    applyStimulus(1, 0, memRd, 0);
    applyStimulus(0, 0, mk(0, 0, 1, 0, 0, 2'd1, 2'd0, 2'd0, 4'h4, 4'h0, 0), 0);

    // STR r3: fetch stall, then MemW held for three cycles
    setInstr(2'b01, 6'b011000, 4'd3, 8'h00, '{2'b01, 2'b10, 3'd0, 1'b0, 1'b0});
    applyStimulus(0, 0, fetchExp(0), 0);
    applyStimulus(1, 0, fetchExp(1), 0);
    applyStimulus(0, 0, decodeExp(), 0);
    applyStimulus(0, 0, memAdr, 0);
    applyStimulus(0, 0, memWr, 0);
    applyStimulus(0, 0, memWr, 0);
    applyStimulus(1, 0, memWr, 0);

    // CMP: all four flags, no register write
    setInstr(2'b00, 6'b010101, 4'd0, 8'h00, '{2'b00, 2'b00, 3'd0, 1'b0, 1'b1});
    applyStimulus(1, 0, fetchExp(1), 0);
    applyStimulus(1, 0, decodeExp(), 0);
    applyStimulus(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'hA, 4'hF, 0), 0);
    applyStimulus(1, 0, idle, 0);

    // TSTS with Rd=15: NZC only, and no PC write
    setInstr(2'b00, 6'b010001, 4'd15, 8'h00, '{2'b00, 2'b00, 3'd0, 1'b0, 1'b1});
    applyStimulus(1, 0, fetchExp(1), 0);
    applyStimulus(1, 0, decodeExp(), 0);
    applyStimulus(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'h8, 4'hE, 0), 0);
    applyStimulus(1, 0, idle, 0);

    // MOV pc,#imm: writeback also writes the PC
    setInstr(2'b00, 6'b111010, 4'd15, 8'h00, '{2'b00, 2'b00, 3'd3, 1'b0, 1'b0});
    applyStimulus(1, 0, fetchExp(1), 0);
    applyStimulus(1, 0, decodeExp(), 0);
    applyStimulus(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 4'hD, 4'h0, 0), 0);
    applyStimulus(1, 0, mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'h4, 4'h0, 0), 0);

    // AND r4 with ASR-by-register: extra SHREG cycle
    setInstr(2'b00, 6'b000000, 4'd4, 8'h05, '{2'b00, 2'b00, 3'd2, 1'b1, 1'b0});
    applyStimulus(1, 0, fetchExp(1), 0);
    applyStimulus(1, 0, decodeExp(), 0);
    applyStimulus(1, 0, idle, 0);
    applyStimulus(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 4'h0, 4'h0, 0), 0);
    applyStimulus(1, 0, mk(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 4'h4, 4'h0, 0), 0);

    // BL: link write only on the BL-enabled instance
    setInstr(2'b11, 6'b000000, 4'd0, 8'h00, '{2'b11, 2'b01, 3'd0, 1'b0, 1'b0});
    applyStimulus(1, 0, fetchExp(1), 0);
    applyStimulus(1, 0, decodeExp(), 0);
    applyStimulus(1, 0, mk(0, 1, 1, 0, 0, 2'd2, 2'd2, 2'd1, 4'h4, 4'h0, 1), 1);

    // plain B
    setInstr(2'b10, 6'b000000, 4'd0, 8'h00, '{2'b10, 2'b01, 3'd0, 1'b0, 1'b0});
    applyStimulus(1, 0, fetchExp(1), 0);
    applyStimulus(1, 0, decodeExp(), 0);
    applyStimulus(1, 0, mk(0, 1, 0, 0, 0, 2'd2, 2'd2, 2'd1, 4'h4, 4'h0, 0), 0);

    // STR aborted by reset in MEMWR; Instr=8'h06 decodes as RRX
    setInstr(2'b01, 6'b011000, 4'd5, 8'h06, '{2'b01, 2'b10, 3'd4, 1'b0, 1'b0});
    applyStimulus(1, 0, fetchExp(1), 0);
    applyStimulus(0, 0, decodeExp(), 0);
    applyStimulus(0, 0, memAdr, 0);
    applyStimulus(0, 0, memWr, 0);
    applyStimulus(0, 1, memRd, 0);
    applyStimulus(1, 0, fetchExp(1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
